// File: rtl/keypad_pkg.sv
// Shared definitions for the PS/2-to-GBA keypad controller: key bit indices,
// scan codes, FSM state encoding and KEYCNT field layout.
package keypad_pkg;

  localparam int KEY_W = 10;

  // Bit positions inside KEYINPUT (active-low, one bit per GBA button).
  localparam logic [3:0] KEY_A      = 4'd0;
  localparam logic [3:0] KEY_B      = 4'd1;
  localparam logic [3:0] KEY_SELECT = 4'd2;
  localparam logic [3:0] KEY_START  = 4'd3;
  localparam logic [3:0] KEY_RIGHT  = 4'd4;
  localparam logic [3:0] KEY_LEFT   = 4'd5;
  localparam logic [3:0] KEY_UP     = 4'd6;
  localparam logic [3:0] KEY_DOWN   = 4'd7;
  localparam logic [3:0] KEY_R      = 4'd8;
  localparam logic [3:0] KEY_L      = 4'd9;

  localparam logic [KEY_W-1:0] KEYS_RELEASED = '1;

  // PS/2 set-2 prefixes and the codes we map.
  localparam logic [7:0] SC_EXT       = 8'hE0;
  localparam logic [7:0] SC_BRK       = 8'hF0;
  localparam logic [7:0] SC_A         = 8'h3B;
  localparam logic [7:0] SC_B         = 8'h42;
  localparam logic [7:0] SC_SELECT    = 8'h31;
  localparam logic [7:0] SC_START     = 8'h3A;
  localparam logic [7:0] SC_RIGHT     = 8'h23;
  localparam logic [7:0] SC_LEFT      = 8'h1C;
  localparam logic [7:0] SC_UP        = 8'h1D;
  localparam logic [7:0] SC_DOWN      = 8'h1B;
  localparam logic [7:0] SC_R         = 8'h43;
  localparam logic [7:0] SC_L         = 8'h3C;
  localparam logic [7:0] SC_EXT_RIGHT = 8'h74;
  localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
  localparam logic [7:0] SC_EXT_UP    = 8'h75;
  localparam logic [7:0] SC_EXT_DOWN  = 8'h72;

  // KEYCNT layout: [9:0] key select, [14] irq enable, [15] AND/OR mode.
  localparam int          KC_SEL_MSB  = 9;
  localparam int          KC_IRQ_EN   = 14;
  localparam int          KC_AND_MODE = 15;
  localparam logic [15:0] KC_WMASK    = 16'hC3FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } kbd_state_e;

  function automatic logic irq_eval(input logic [15:0] kc, input logic [KEY_W-1:0] keys);
    logic [KEY_W-1:0] sel;
    logic [KEY_W-1:0] hit;
    sel = kc[KC_SEL_MSB:0];
    hit = sel & ~keys;
    if (!kc[KC_IRQ_EN])
      irq_eval = 1'b0;
    else if (kc[KC_AND_MODE])
      irq_eval = (sel != '0) && (hit == sel);
    else
      irq_eval = |hit;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational scan-code lookup: (code, ext) -> {hit, key index}.
module keypad_decode
  import keypad_pkg::*;
#(
  parameter bit ARROW_ALIAS = 1'b1
) (
  input  logic [7:0] code,
  input  logic       ext,
  output logic       hit,
  output logic [3:0] index
);

  always_comb begin
    hit   = 1'b0;
    index = '0;
    if (!ext) begin
      unique case (code)
        SC_A:      begin hit = 1'b1; index = KEY_A;      end
        SC_B:      begin hit = 1'b1; index = KEY_B;      end
        SC_SELECT: begin hit = 1'b1; index = KEY_SELECT; end
        SC_START:  begin hit = 1'b1; index = KEY_START;  end
        SC_RIGHT:  begin hit = 1'b1; index = KEY_RIGHT;  end
        SC_LEFT:   begin hit = 1'b1; index = KEY_LEFT;   end
        SC_UP:     begin hit = 1'b1; index = KEY_UP;     end
        SC_DOWN:   begin hit = 1'b1; index = KEY_DOWN;   end
        SC_R:      begin hit = 1'b1; index = KEY_R;      end
        SC_L:      begin hit = 1'b1; index = KEY_L;      end
        default:   ;
      endcase
    end else if (ARROW_ALIAS) begin
      // Extended codes only ever reach the D-pad; everything else under E0 is dropped.
      unique case (code)
        SC_EXT_RIGHT: begin hit = 1'b1; index = KEY_RIGHT; end
        SC_EXT_LEFT:  begin hit = 1'b1; index = KEY_LEFT;  end
        SC_EXT_UP:    begin hit = 1'b1; index = KEY_UP;    end
        SC_EXT_DOWN:  begin hit = 1'b1; index = KEY_DOWN;  end
        default:      ;
      endcase
    end
  end

endmodule

// File: rtl/keypad_ctrl.sv
// Drains PS/2 scan codes from a FIFO into GBA KEYINPUT, with optional
// KEYCNT/interrupt logic enabled by the KEYPAD_IRQ_EN macro.
module keypad_ctrl
  import keypad_pkg::*;
#(
  parameter bit ARROW_ALIAS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        kbd_data,
  input  logic              kbd_ready,
  input  logic              kbd_overflow,
  output logic              kbd_nextdata_n,
  output logic [KEY_W-1:0]  keyinput,
  input  logic              keycnt_wr,
  input  logic [15:0]       keycnt_wdata,
  output logic [15:0]       keycnt,
  output logic              irq
);

  // FIFO handshake: kbd_ready high means kbd_data is valid; a one-cycle low on
  // kbd_nextdata_n pops it. GAP gives the FIFO a cycle to update ready/data.
  kbd_state_e       state_q, state_d;
  logic [7:0]       code_q, code_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic             ovf_q, ovf_d;
  logic [KEY_W-1:0] keys_q, keys_d;
  logic             ovf_rise;
  logic             dec_hit;
  logic [3:0]       dec_index;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (kbd_ready) state_d = POP;
      POP:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    kbd_nextdata_n = (state_q != POP);
  end

  keypad_decode #(
    .ARROW_ALIAS (ARROW_ALIAS)
  ) u_decode (
    .code  (code_q),
    .ext   (ext_q),
    .hit   (dec_hit),
    .index (dec_index)
  );

  always_comb begin
    code_d   = code_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    keys_d   = keys_q;
    ovf_d    = kbd_overflow;
    ovf_rise = kbd_overflow & ~ovf_q;
    if (state_q == IDLE && kbd_ready) code_d = kbd_data;
    // A fresh overflow means make/break pairs were lost: release everything.
    if (ovf_rise) begin
      keys_d = KEYS_RELEASED;
      ext_d  = 1'b0;
      brk_d  = 1'b0;
    end else if (state_q == POP) begin
      if (code_q == SC_EXT) begin
        ext_d = 1'b1;
      end else if (code_q == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (dec_hit) keys_d[dec_index] = brk_q;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= '0;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      ovf_q  <= 1'b0;
      keys_q <= KEYS_RELEASED;
    end else begin
      code_q <= code_d;
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      ovf_q  <= ovf_d;
      keys_q <= keys_d;
    end
  end

  assign keyinput = keys_q;

`ifdef KEYPAD_IRQ_EN
  logic [15:0] keycnt_q, keycnt_d;
  logic        irq_q, irq_d;

  always_comb begin
    keycnt_d = keycnt_q;
    if (keycnt_wr) keycnt_d = keycnt_wdata & KC_WMASK;
    irq_d = irq_eval(keycnt_q, keys_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      keycnt_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      keycnt_q <= keycnt_d;
      irq_q    <= irq_d;
    end
  end

  assign keycnt = keycnt_q;
  assign irq    = irq_q;
`else
  logic unused_keycnt;
  assign unused_keycnt = ^{keycnt_wr, keycnt_wdata};
  assign keycnt        = '0;
  assign irq           = 1'b0;
`endif

  pop_single_cycle: assert property (@(posedge clk) disable iff (rst)
    !kbd_nextdata_n |=> kbd_nextdata_n);

endmodule

// File: tb/tb_keypad_ctrl.sv
// Self-checking bench for keypad_ctrl; IRQ checks follow the KEYPAD_IRQ_EN build.
module tb_keypad_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  kbd_data;
  logic        kbd_ready;
  logic        kbd_overflow;
  logic        keycnt_wr;
  logic [15:0] keycnt_wdata;
  logic        kbd_nextdata_n;
  logic [9:0]  keyinput;
  logic [15:0] keycnt;
  logic        irq;
  logic        nd0;
  logic [9:0]  key0;
  logic [15:0] kc0;
  logic        irq0;

  int n_chk = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  logic irq_at_upd, irq_after;

  logic [7:0] tx_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] exp0_q[$];
  logic [9:0]  m_key1, m_key0;
  logic        m_ext, m_brk;
  logic [15:0] m_keycnt;

  keypad_ctrl #(.ARROW_ALIAS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n),
    .keyinput(keyinput), .keycnt_wr(keycnt_wr), .keycnt_wdata(keycnt_wdata),
    .keycnt(keycnt), .irq(irq)
  );

  keypad_ctrl #(.ARROW_ALIAS(1'b0)) u_dut_noalias (
    .clk(clk), .rst(rst), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .kbd_overflow(kbd_overflow), .kbd_nextdata_n(nd0),
    .keyinput(key0), .keycnt_wr(keycnt_wr), .keycnt_wdata(keycnt_wdata),
    .keycnt(kc0), .irq(irq0)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic int key_of(input logic [7:0] b, input logic ext, input bit alias_en);
    key_of = -1;
    if (!ext) begin
      case (b)
        8'h3B: key_of = 0;
        8'h42: key_of = 1;
        8'h31: key_of = 2;
        8'h3A: key_of = 3;
        8'h23: key_of = 4;
        8'h1C: key_of = 5;
        8'h1D: key_of = 6;
        8'h1B: key_of = 7;
        8'h43: key_of = 8;
        8'h3C: key_of = 9;
        default: ;
      endcase
    end else if (alias_en) begin
      case (b)
        8'h74: key_of = 4;
        8'h6B: key_of = 5;
        8'h75: key_of = 6;
        8'h72: key_of = 7;
        default: ;
      endcase
    end
  endfunction

  function automatic logic irq_model(input logic [15:0] kc, input logic [9:0] keys);
    logic [9:0] p;
    logic [9:0] s;
    p = ~keys;
    s = kc[9:0];
    if (!kc[14]) return 1'b0;
    if (kc[15]) return (s != 10'd0) && ((p & s) == s);
    return |(p & s);
  endfunction

  task automatic model_reset();
    m_key1 = 10'h3FF; m_key0 = 10'h3FF;
    m_ext = 1'b0; m_brk = 1'b0; m_keycnt = 16'h0000;
    exp_q.delete(); exp0_q.delete(); tx_q.delete();
  endtask

  // driver: queue a byte and push the expected KEYINPUT after it is consumed
  task automatic push_byte(input logic [7:0] b);
    int k1, k0;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      k1 = key_of(b, m_ext, 1'b1);
      k0 = key_of(b, m_ext, 1'b0);
      if (k1 >= 0) m_key1[k1] = m_brk;
      if (k0 >= 0) m_key0[k0] = m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    tx_q.push_back(b);
    exp_q.push_back(m_key1);
    exp0_q.push_back(m_key0);
  endtask

  // FIFO model + scoreboard: present bytes, pop on strobe, compare after each pop
  task automatic run_stream();
    int guard;
    logic prev_pop;
    logic [7:0] cur;
    logic [9:0] e1, e0;
    guard = 0; prev_pop = 1'b0; cur = 8'h00;
    @(negedge clk);
    if (tx_q.size() > 0) begin kbd_data = tx_q[0]; kbd_ready = 1'b1; end
    while ((tx_q.size() > 0 || prev_pop) && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (prev_pop) begin
        n_chk++;
        if (kbd_nextdata_n !== 1'b1) begin
          n_fail++;
          $display("FAIL pop_gap: byte %02h strobe low two cycles (got %b, want 1)", cur, kbd_nextdata_n);
        end
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL scoreboard_empty: byte %02h has no expected value", cur);
        end else begin
          e1 = exp_q.pop_front();
          e0 = exp0_q.pop_front();
          n_chk++;
          if (keyinput !== e1) begin
            n_fail++;
            $display("FAIL keyinput: after byte %02h got %03h want %03h", cur, keyinput, e1);
          end
          n_chk++;
          if (key0 !== e0) begin
            n_fail++;
            $display("FAIL keyinput_noalias: after byte %02h got %03h want %03h", cur, key0, e0);
          end
        end
        irq_at_upd = irq;
        prev_pop = 1'b0;
      end else if (kbd_nextdata_n === 1'b0) begin
        pulse_cnt++;
        cur = tx_q.pop_front();
        if (tx_q.size() > 0) kbd_data = tx_q[0];
        else kbd_ready = 1'b0;
        prev_pop = 1'b1;
      end
    end
    if (guard >= 3000) begin
      n_chk++; n_fail++;
      $display("FAIL stream_timeout: %0d bytes left unconsumed, want 0", tx_q.size());
      kbd_ready = 1'b0;
      tx_q.delete();
    end
    @(negedge clk);
    irq_after = irq;
  endtask

  task automatic write_keycnt(input logic [15:0] v);
    @(negedge clk);
    keycnt_wr = 1'b1; keycnt_wdata = v;
`ifdef KEYPAD_IRQ_EN
    m_keycnt = v & 16'hC3FF;
`endif
    @(negedge clk);
    keycnt_wr = 1'b0;
    n_chk++;
    if (keycnt !== m_keycnt) begin
      n_fail++;
      $display("FAIL keycnt_write: wrote %04h got %04h want %04h", v, keycnt, m_keycnt);
    end
    @(negedge clk);
    n_chk++;
    if (irq !== irq_model(m_keycnt, m_key1)) begin
      n_fail++;
      $display("FAIL irq_after_write: keycnt %04h got %b want %b", m_keycnt, irq, irq_model(m_keycnt, m_key1));
    end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1; kbd_data = 8'h00; kbd_ready = 1'b0; kbd_overflow = 1'b0;
    keycnt_wr = 1'b0; keycnt_wdata = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (keyinput !== 10'h3FF) begin n_fail++; $display("FAIL reset_keyinput: got %03h want 3ff", keyinput); end
    n_chk++; if (kbd_nextdata_n !== 1'b1) begin n_fail++; $display("FAIL reset_nextdata: got %b want 1", kbd_nextdata_n); end
    n_chk++; if (keycnt !== 16'h0000) begin n_fail++; $display("FAIL reset_keycnt: got %04h want 0000", keycnt); end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst = 1'b0;
  endtask

  task automatic test_make_break();
    pulse_cnt = 0;
    push_byte(8'h3B);
    run_stream();
    n_chk++; if (keyinput !== 10'h3FE) begin n_fail++; $display("FAIL make_a: got %03h want 3fe", keyinput); end
    push_byte(8'hF0); push_byte(8'h3B);
    run_stream();
    n_chk++; if (keyinput !== 10'h3FF) begin n_fail++; $display("FAIL break_a: got %03h want 3ff", keyinput); end
    n_chk++; if (pulse_cnt != 3) begin n_fail++; $display("FAIL pop_pulses: got %0d want 3", pulse_cnt); end
  endtask

  task automatic test_arrows();
    push_byte(8'hE0); push_byte(8'h75);
    run_stream();
    n_chk++; if (keyinput !== 10'h3BF) begin n_fail++; $display("FAIL ext_up_alias: got %03h want 3bf", keyinput); end
    n_chk++; if (key0 !== 10'h3FF) begin n_fail++; $display("FAIL ext_up_noalias: got %03h want 3ff", key0); end
    push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
    run_stream();
    n_chk++; if (keyinput !== 10'h3FF) begin n_fail++; $display("FAIL ext_up_release: got %03h want 3ff", keyinput); end
  endtask

  task automatic test_unmapped();
    push_byte(8'h55);
    push_byte(8'hE0); push_byte(8'h11);
    push_byte(8'hE0); push_byte(8'h3B);
    push_byte(8'h1B); push_byte(8'h1B);
    push_byte(8'h3C);
    push_byte(8'hF0); push_byte(8'h1B);
    run_stream();
    n_chk++; if (keyinput !== 10'h1FF) begin n_fail++; $display("FAIL unmapped_final: got %03h want 1ff", keyinput); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes [0:19];
    codes = '{8'h3B, 8'h42, 8'h31, 8'h3A, 8'h23, 8'h1C, 8'h1D, 8'h1B, 8'h43, 8'h3C,
              8'h74, 8'h6B, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'hF0, 8'hE0, 8'h29, 8'h5A};
    for (int i = 0; i < 60; i++) push_byte(codes[$urandom_range(0, 19)]);
    run_stream();
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    push_byte(8'h1D); push_byte(8'h23); push_byte(8'hF0);
    run_stream();
    @(negedge clk);
    kbd_overflow = 1'b1;
    @(negedge clk);
    m_key1 = 10'h3FF; m_key0 = 10'h3FF; m_ext = 1'b0; m_brk = 1'b0;
    n_chk++; if (keyinput !== 10'h3FF) begin n_fail++; $display("FAIL overflow_clear: got %03h want 3ff", keyinput); end
    n_chk++; if (key0 !== 10'h3FF) begin n_fail++; $display("FAIL overflow_clear_noalias: got %03h want 3ff", key0); end
    kbd_overflow = 1'b0;
    push_byte(8'h3B);
    run_stream();
    n_chk++; if (keyinput !== 10'h3FE) begin n_fail++; $display("FAIL overflow_flags: got %03h want 3fe", keyinput); end
  endtask

`ifdef KEYPAD_IRQ_EN
  task automatic test_irq();
    write_keycnt(16'hFFFF);
    write_keycnt(16'hC003);
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_and_a_only: got %b want 0", irq); end
    push_byte(8'h42);
    run_stream();
    n_chk++; if (irq_at_upd !== 1'b0) begin n_fail++; $display("FAIL irq_latency: got %b want 0 on update cycle", irq_at_upd); end
    n_chk++; if (irq_after !== 1'b1) begin n_fail++; $display("FAIL irq_and_ab: got %b want 1", irq_after); end
    push_byte(8'hF0); push_byte(8'h42);
    run_stream();
    n_chk++; if (irq_after !== 1'b0) begin n_fail++; $display("FAIL irq_and_release: got %b want 0", irq_after); end
    write_keycnt(16'h4003);
    n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_or_a: got %b want 1", irq); end
    write_keycnt(16'h0003);
  endtask
`else
  task automatic test_irq_disabled();
    write_keycnt(16'hFFFF);
    foreach (m_key1[i]) begin end
    push_byte(8'h3B); push_byte(8'h42); push_byte(8'h31); push_byte(8'h3A); push_byte(8'h23);
    push_byte(8'h1C); push_byte(8'h1D); push_byte(8'h1B); push_byte(8'h43); push_byte(8'h3C);
    run_stream();
    n_chk++; if (keyinput !== 10'h000) begin n_fail++; $display("FAIL all_pressed: got %03h want 000", keyinput); end
    n_chk++; if (keycnt !== 16'h0000) begin n_fail++; $display("FAIL keycnt_disabled: got %04h want 0000", keycnt); end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled: got %b want 0", irq); end
  endtask
`endif

  task automatic test_reset_mid_pop();
    int guard;
`ifdef KEYPAD_IRQ_EN
    write_keycnt(16'h4008);
`endif
    push_byte(8'h3A);
    run_stream();
    @(negedge clk);
    kbd_data = 8'h3B; kbd_ready = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (kbd_nextdata_n !== 1'b0 && guard < 20);
    n_chk++; if (kbd_nextdata_n !== 1'b0) begin n_fail++; $display("FAIL mid_pop_reach: got %b want 0", kbd_nextdata_n); end
    rst = 1'b1; kbd_ready = 1'b0;
    @(negedge clk);
    model_reset();
    n_chk++; if (kbd_nextdata_n !== 1'b1) begin n_fail++; $display("FAIL rst_pop_nextdata: got %b want 1", kbd_nextdata_n); end
    n_chk++; if (keyinput !== 10'h3FF) begin n_fail++; $display("FAIL rst_pop_keyinput: got %03h want 3ff", keyinput); end
    n_chk++; if (keycnt !== 16'h0000) begin n_fail++; $display("FAIL rst_pop_keycnt: got %04h want 0000", keycnt); end
    rst = 1'b0;
    push_byte(8'h43);
    run_stream();
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_arrows();
    test_unmapped();
    test_back_to_back();
    test_overflow();
`ifdef KEYPAD_IRQ_EN
    test_irq();
`else
    test_irq_disabled();
`endif
    test_reset_mid_pop();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
